frog_game_ctrl: RTL and testbench
=================================

# frog_game_ctrl

Gameplay controller that sits directly upstream of the VGA display stage. It turns the four raw direction buttons into the frog's grid position and detects collisions against the 16 car positions. It maintains the life count, level and game-over state. Its frog position and life count drive the display's `frog_col`, `frog_row` and `lives` inputs. It reads the same car coordinate buses the display consumes.

## Interface
- `GRID_COLS`, 20: playfield width in cells (640/32).
- `GRID_ROWS`, 15: playfield height in cells (480/32).
- `START_COL`, 10: frog spawn column.
- `START_ROW`, 14: frog spawn row (bottom).
- `LIVES_INIT`, 3: lives after reset or restart (fits 2 bits).
- `DEBOUNCE_CYC`, 250_000: cycles a synchronised button must stay stable before it is accepted.
- `FREEZE_CYC`, 25_000_000: input lockout after a hit (1 s at 25 MHz).
- `clk`  in  1  pixel clock, single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw, asynchronous, active-high buttons.
- `car_x`  in  80  16 × 5-bit car columns; car k occupies bits [5k+4:5k].
- `car_y`  in  64  16 × 4-bit car rows; car k occupies bits [4k+3:4k].
- `frog_col`  out  5  frog column, registered.
- `frog_row`  out  4  frog row, registered.
- `lives`  out  2  remaining lives, registered.
- `level`  out  4  crossings completed, saturating at 15.
- `game_over`  out  1  high while in GAME_OVER.
- `win_pulse`  out  1  one-cycle pulse on each successful crossing.

## Operation
- **Button conditioning** (per button):
  - Two-flop synchroniser, then a stability counter.
  - The debounced level changes only after `DEBOUNCE_CYC` consecutive equal samples.
  - A 1-cycle `press` pulse fires on each debounced 0→1 transition.
  - Holding a button never repeats the pulse.
- **States:** PLAY, FREEZE, GAME_OVER. Reset enters PLAY.
- **`hit`:** combinational; true when any car k has `car_x[k]==frog_col` and `car_y[k]==frog_row`. All 16 cars are compared in parallel.
- **PLAY**, evaluated in this priority order each cycle:
  1. `hit`:
     - Frog returns to (`START_COL`, `START_ROW`).
     - If `lives==1`: lives becomes 0 and the state goes to GAME_OVER.
     - Otherwise: lives is decremented, the freeze counter is loaded with `FREEZE_CYC-1`, and the state goes to FREEZE.
     - Any press in the same cycle is discarded.
  2. `frog_row==0` (far bank reached):
     - Frog returns to start.
     - `win_pulse`=1 for one cycle.
     - `level` += 1, saturating at 15.
     - Presses in the same cycle are discarded.
  3. Otherwise, one press is applied, with priority up > down > left > right:
     - up: row−1.
     - down: row+1.
     - left: col−1.
     - right: col+1.
     - Moves are clamped at the edges: row stays within 0..`GRID_ROWS-1` and col within 0..`GRID_COLS-1`. A clamped move leaves the position unchanged. There is no wrap-around.
- **FREEZE:**
  - Presses are ignored and collisions are ignored.
  - The counter decrements each cycle; at 0 the state returns to PLAY.
- **GAME_OVER:**
  - `game_over`=1; the frog is held at start and `lives`=0.
  - Any press restarts the game: `lives`=`LIVES_INIT`, `level`=0, frog at start, state PLAY. The restarting press does not also move the frog.
- **`rst_n` low at a rising edge** (including mid-FREEZE or mid-debounce) clears all internal state:
  - Debounce counters and debounced levels go to 0.
  - Outputs take their reset values on that edge.

## Timing
- **Reset values:**
  - `frog_col`=`START_COL`, `frog_row`=`START_ROW`.
  - `lives`=`LIVES_INIT`.
  - `level`=0, `game_over`=0, `win_pulse`=0.
- **Button latency:** a raw edge held stable produces a press pulse 2 (sync) + `DEBOUNCE_CYC` cycles later. The position register updates on the edge after the pulse.
- **Collision latency:** coincidence is observed in cycle N. `lives`, position and state change at the edge ending cycle N.
- **Win latency:** `win_pulse` is high in the cycle after `frog_row` first reads 0.
- **Freeze length:** the FREEZE state lasts exactly `FREEZE_CYC` cycles.
- **Simultaneous events:**
  - hit and row 0 together: hit wins.
  - Multiple presses in one cycle: only the highest-priority press is applied; the others are lost.

## Structure
- **Shared package `frog_pkg`:**
  - State encoding (PLAY, FREEZE, GAME_OVER).
  - `NUM_CARS`=16, `CELL_PX`=32, `COL_W`=5, `ROW_W`=4.
  - Grid dimensions for use by the display and the car movers.
- **Sub-module `button_debounce`:** synchroniser, stability counter and rising-edge pulse, parameterised by `DEBOUNCE_CYC`. It is instantiated four times.
- **Top level:** collision compare, FSM and counters stay in the top level.

## Test plan
Parameters for the bench: `DEBOUNCE_CYC`=4, `FREEZE_CYC`=8, `GRID_COLS`=20, `GRID_ROWS`=15, `START_COL`=10, `START_ROW`=14.

- **Reset/move:** reset, then a clean `btn_up` press → frog (10,13). `btn_right` ×10 → col clamps at 19 and never wraps.
- **Bounce/hold:** toggle `btn_left` every 2 cycles for 20 cycles, then hold it for 50 cycles → exactly one step to col 9.
- **Hit:** car 5 = (10,14) while the frog is at start → frog (10,14), lives 2, FREEZE for 8 cycles. A press during FREEZE does not move the frog.
- **Game over:** three hits → lives 0 and `game_over`=1. A `btn_down` press → lives 3, level 0, `game_over`=0, frog (10,14).
- **Win:** 14 up presses with no cars → `win_pulse` for one cycle, level 1, frog back at (10,14). Repeated 16 times → level saturates at 15.
- **Priority:** hit and row 0 in the same cycle → lives decremented, no `win_pulse`. `btn_up` and `btn_left` in the same cycle → only the row changes.

Source files
------------

// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - shared types and constants for the frog gameplay blocks
// Purpose: game state encoding, car/grid geometry used by the controller,
//          the display stage and the car movers.
// Ports:   none (package).
package frog_pkg;

    localparam int NUM_CARS      = 16;
    localparam int CELL_PX       = 32;
    localparam int COL_W         = 5;
    localparam int ROW_W         = 4;
    localparam int GRID_COLS_DEF = 640 / CELL_PX;
    localparam int GRID_ROWS_DEF = 480 / CELL_PX;

    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_FREEZE    = 2'd1,
        ST_GAME_OVER = 2'd2
    } game_state_e;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser, stability filter and press pulse for one button
// Purpose: condition one raw asynchronous button into a single-cycle press pulse.
// Ports:   clk, rst_n       - clock, synchronous active-low reset
//          btn_i            - raw asynchronous active-high button
//          press_o          - one-cycle pulse on each debounced 0->1 transition
module button_debounce #(
    parameter int DEBOUNCE_CYC = 250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any agreeing sample restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/frog_game_ctrl.sv
// rtl/frog_game_ctrl.sv - frog position, collision, lives, level and game-over control
// Purpose: turns debounced direction presses into frog grid moves, detects
//          collisions against 16 cars, and runs the PLAY/FREEZE/GAME_OVER FSM.
// Ports:   clk, rst_n                          - clock, synchronous active-low reset
//          btn_up/down/left/right              - raw asynchronous buttons
//          car_x [80], car_y [64]              - packed car columns / rows
//          frog_col, frog_row, lives, level    - registered game state
//          game_over                           - high while in GAME_OVER
//          win_pulse                           - one-cycle pulse per crossing
module frog_game_ctrl
    import frog_pkg::*;
#(
    parameter int GRID_COLS    = 20,
    parameter int GRID_ROWS    = 15,
    parameter int START_COL    = 10,
    parameter int START_ROW    = 14,
    parameter int LIVES_INIT   = 3,
    parameter int DEBOUNCE_CYC = 250_000,
    parameter int FREEZE_CYC   = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic [NUM_CARS*COL_W-1:0] car_x,
    input  logic [NUM_CARS*ROW_W-1:0] car_y,
    output logic [COL_W-1:0]          frog_col,
    output logic [ROW_W-1:0]          frog_row,
    output logic [1:0]                lives,
    output logic [3:0]                level,
    output logic                      game_over,
    output logic                      win_pulse
);

    localparam int FRZ_W = $clog2(FREEZE_CYC + 1);
    localparam logic [FRZ_W-1:0] FRZ_LOAD   = FRZ_W'(FREEZE_CYC - 1);
    localparam logic [COL_W-1:0] START_C    = COL_W'(START_COL);
    localparam logic [ROW_W-1:0] START_R    = ROW_W'(START_ROW);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(GRID_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(GRID_ROWS - 1);
    localparam logic [1:0]       LIVES_RST  = 2'(LIVES_INIT);

    game_state_e       state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [1:0]        lives_q, lives_d;
    logic [3:0]        level_q, level_d;
    logic [FRZ_W-1:0]  frz_q, frz_d;
    logic              win_q, win_d;

    logic press_up, press_down, press_left, press_right;
    logic any_press;
    logic hit;

    button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_up), .press_o(press_up)
    );
    button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_down), .press_o(press_down)
    );
    button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_left (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_left), .press_o(press_left)
    );
    button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_right (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_right), .press_o(press_right)
    );

    assign any_press = press_up | press_down | press_left | press_right;

    // All cars compared in parallel against the registered frog position.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NUM_CARS; k++) begin
            if ((car_x[k*COL_W +: COL_W] == col_q) &&
                (car_y[k*ROW_W +: ROW_W] == row_q)) begin
                hit = 1'b1;
            end
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_PLAY;
            col_q   <= START_C;
            row_q   <= START_R;
            lives_q <= LIVES_RST;
            level_q <= 4'd0;
            frz_q   <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            lives_q <= lives_d;
            level_q <= level_d;
            frz_q   <= frz_d;
            win_q   <= win_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PLAY: begin
                if (hit) begin
                    state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                if (frz_q == '0) begin
                    state_d = ST_PLAY;
                end
            end
            ST_GAME_OVER: begin
                if (any_press) begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    // Datapath next values: hit beats the far bank, which beats any press.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        lives_d = lives_q;
        level_d = level_q;
        frz_d   = frz_q;
        win_d   = 1'b0;
        case (state_q)
            ST_PLAY: begin
                if (hit) begin
                    col_d   = START_C;
                    row_d   = START_R;
                    lives_d = lives_q - 1'b1;
                    if (lives_q != 2'd1) begin
                        frz_d = FRZ_LOAD;
                    end
                end else if (row_q == '0) begin
                    col_d = START_C;
                    row_d = START_R;
                    win_d = 1'b1;
                    if (level_q != 4'hF) begin
                        level_d = level_q + 1'b1;
                    end
                end else if (press_up) begin
                    if (row_q != '0) row_d = row_q - 1'b1;
                end else if (press_down) begin
                    if (row_q != ROW_LAST) row_d = row_q + 1'b1;
                end else if (press_left) begin
                    if (col_q != '0) col_d = col_q - 1'b1;
                end else if (press_right) begin
                    if (col_q != COL_LAST) col_d = col_q + 1'b1;
                end
            end
            ST_FREEZE: begin
                if (frz_q != '0) begin
                    frz_d = frz_q - 1'b1;
                end
            end
            ST_GAME_OVER: begin
                col_d   = START_C;
                row_d   = START_R;
                lives_d = 2'd0;
                if (any_press) begin
                    lives_d = LIVES_RST;
                    level_d = 4'd0;
                end
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        frog_col  = col_q;
        frog_row  = row_q;
        lives     = lives_q;
        level     = level_q;
        win_pulse = win_q;
        game_over = (state_q == ST_GAME_OVER);
    end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// tb/tb_frog_game_ctrl.sv - scoreboard bench for frog_game_ctrl
module tb_frog_game_ctrl;
    import frog_pkg::*;

    localparam int DB  = 4;
    localparam int FRZ = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [79:0] car_x;
    logic [63:0] car_y;
    logic [4:0]  frog_col;
    logic [3:0]  frog_row;
    logic [1:0]  lives;
    logic [3:0]  level;
    logic        game_over;
    logic        win_pulse;

    always #5 clk = ~clk;

    frog_game_ctrl #(
        .GRID_COLS(20), .GRID_ROWS(15), .START_COL(10), .START_ROW(14),
        .LIVES_INIT(3), .DEBOUNCE_CYC(DB), .FREEZE_CYC(FRZ)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .car_x(car_x), .car_y(car_y),
        .frog_col(frog_col), .frog_row(frog_row), .lives(lives), .level(level),
        .game_over(game_over), .win_pulse(win_pulse)
    );

    typedef struct {
        string      name;
        logic [4:0] col;
        logic [3:0] row;
        logic [1:0] lives;
        logic [3:0] level;
        logic       go;
        logic       win;
        int         gap;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    logic [16:0] prev_snap = '1;

    // Expected-state variables, advanced by hand at each directed step.
    logic [4:0] e_col;
    logic [3:0] e_row;
    logic [1:0] e_lives;
    logic [3:0] e_level;
    logic       e_go, e_win;

    task automatic expect_ev(input string name, input int gap);
        ev_t e;
        e.name = name; e.col = e_col; e.row = e_row; e.lives = e_lives;
        e.level = e_level; e.go = e_go; e.win = e_win; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic set_car(input int k, input logic [4:0] x, input logic [3:0] y);
        car_x[k*5 +: 5] = x;
        car_y[k*4 +: 4] = y;
    endtask

    task automatic park_all();
        for (int k = 0; k < 16; k++) set_car(k, 5'd31, 4'd15);
    endtask

    task automatic drive_btn(input int b, input logic v);
        case (b)
            0: btn_up = v;
            1: btn_down = v;
            2: btn_left = v;
            default: btn_right = v;
        endcase
    endtask

    task automatic press(input int b);
        @(negedge clk);
        drive_btn(b, 1'b1);
        repeat (DB + 6) @(negedge clk);
        drive_btn(b, 1'b0);
        repeat (DB + 6) @(negedge clk);
    endtask

    // Monitor: every change of the observable tuple is one DUT output event.
    always @(negedge clk) begin
        logic [16:0] snap;
        logic [16:0] want;
        ev_t e;
        cyc = cyc + 1;
        snap = {frog_col, frog_row, lives, level, game_over, win_pulse};
        if (snap !== prev_snap) begin
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: got col=%0d row=%0d lives=%0d level=%0d go=%0b win=%0b, expected no change",
                         frog_col, frog_row, lives, level, game_over, win_pulse);
            end else begin
                e = exp_q.pop_front();
                want = {e.col, e.row, e.lives, e.level, e.go, e.win};
                if (snap === want) n_pass = n_pass + 1;
                else $display("FAIL %s: got col=%0d row=%0d lives=%0d level=%0d go=%0b win=%0b, expected col=%0d row=%0d lives=%0d level=%0d go=%0b win=%0b",
                              e.name, frog_col, frog_row, lives, level, game_over, win_pulse,
                              e.col, e.row, e.lives, e.level, e.go, e.win);
                if (e.gap >= 0) begin
                    n_checks = n_checks + 1;
                    if (cyc - last_cyc == e.gap) n_pass = n_pass + 1;
                    else $display("FAIL %s_gap: got %0d cycles, expected %0d", e.name, cyc - last_cyc, e.gap);
                end
            end
            prev_snap = snap;
            last_cyc = cyc;
        end
    end

    initial begin
        park_all();
        e_col = 5'd10; e_row = 4'd14; e_lives = 2'd3; e_level = 4'd0; e_go = 1'b0; e_win = 1'b0;
        expect_ev("reset", -1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        e_row = 4'd13; expect_ev("up_move", -1);
        press(0);

        // Bouncing input never stays stable long enough; the hold gives one step.
        e_col = 5'd9; expect_ev("bounce_hold_left", -1);
        for (int i = 0; i < 10; i++) begin
            btn_left = ~btn_left;
            repeat (2) @(negedge clk);
        end
        btn_left = 1'b1;
        repeat (50) @(negedge clk);
        btn_left = 1'b0;
        repeat (DB + 6) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (e_col < 5'd19) begin
                e_col = e_col + 1'b1;
                expect_ev("right_move", -1);
            end
            press(3);
        end

        e_row = 4'd14; expect_ev("down_move", -1);
        press(1);
        press(1);

        for (int c = 0; c < 16; c++) begin
            for (int r = 0; r < 13; r++) begin
                e_row = e_row - 1'b1;
                expect_ev("cross_up", -1);
                press(0);
            end
            e_row = 4'd0; expect_ev("reach_bank", -1);
            e_col = 5'd10; e_row = 4'd14; e_win = 1'b1;
            if (e_level != 4'hF) e_level = e_level + 1'b1;
            expect_ev("win_pulse", 1);
            e_win = 1'b0; expect_ev("win_clear", 1);
            press(0);
        end

        e_row = 4'd13; expect_ev("up_beats_left", -1);
        @(negedge clk);
        btn_up = 1'b1; btn_left = 1'b1;
        repeat (DB + 6) @(negedge clk);
        btn_up = 1'b0; btn_left = 1'b0;
        repeat (DB + 6) @(negedge clk);

        e_row = 4'd14; expect_ev("back_to_start", -1);
        press(1);

        // Car parked on the spawn cell: hits repeat after each freeze; the held
        // button's press lands inside the first freeze and must not move the frog.
        e_lives = 2'd2; expect_ev("hit1", -1);
        e_lives = 2'd1; expect_ev("hit2", FRZ + 1);
        e_lives = 2'd0; e_go = 1'b1; expect_ev("hit3_game_over", FRZ + 1);
        @(negedge clk);
        set_car(5, 5'd10, 4'd14);
        btn_up = 1'b1;
        repeat (40) @(negedge clk);
        btn_up = 1'b0;
        repeat (DB + 6) @(negedge clk);
        park_all();

        e_lives = 2'd3; e_level = 4'd0; e_go = 1'b0; expect_ev("restart", -1);
        press(0);
        repeat (5) @(negedge clk);

        set_car(3, 5'd10, 4'd0);
        for (int r = 0; r < 13; r++) begin
            e_row = e_row - 1'b1;
            expect_ev("climb_to_car", -1);
            press(0);
        end
        e_row = 4'd0; expect_ev("bank_with_car", -1);
        e_row = 4'd14; e_lives = 2'd2; expect_ev("hit_beats_win", 1);
        press(0);
        repeat (12) @(negedge clk);
        park_all();

        e_lives = 2'd1; expect_ev("hit_before_reset", -1);
        @(negedge clk);
        set_car(5, 5'd10, 4'd14);
        repeat (3) @(negedge clk);
        park_all();
        e_lives = 2'd3; expect_ev("reset_in_freeze", -1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        e_col = 5'd9; expect_ev("move_after_reset", -1);
        press(2);
        repeat (20) @(negedge clk);

        n_checks = n_checks + 1;
        if (exp_q.size() == 0) n_pass = n_pass + 1;
        else $display("FAIL pending_events: got %0d unobserved, expected 0 (next %s)", exp_q.size(), exp_q[0].name);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
